// File: rtl/wr_decode_scoreboard_pkg.sv
// Shared definitions for the writeback decoder / busy scoreboard slice:
// default address width, derived register count, busy counter width and
// the one-hot decode primitive used by decoder_n.
package wr_decode_scoreboard_pkg;

   localparam int ADDR_W_DEF     = 5;
   localparam int NREG_DEF       = 1 << ADDR_W_DEF;
   localparam int BUSY_CNT_W_DEF = ADDR_W_DEF + 1;

   // A counter of set busy bits must hold the value NREG, hence one extra bit.
   function automatic int busy_cnt_width(input int addr_w);
      return addr_w + 1;
   endfunction

   // Bit idx of the one-hot code for addr.
   function automatic logic onehot_decode(input int unsigned addr, input int unsigned idx);
      return (addr == idx);
   endfunction

endpackage

// File: rtl/wr_decode_scoreboard_decoder_n.sv
// Parametrised ADDR_W-to-2**ADDR_W combinational one-hot decoder with enable.
// With en low the output is all zeros.
module decoder_n
   import wr_decode_scoreboard_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic                     en,
   input  logic [ADDR_W-1:0]        addr,
   output logic [(1<<ADDR_W)-1:0]   onehot
);

   // Build each output bit from the shared decode primitive, gated by en.
   always_comb begin
      onehot = '0;
      for (int i = 0; i < (1 << ADDR_W); i++) begin
         onehot[i] = en & onehot_decode(32'(addr), i);
      end
   end

endmodule

// File: rtl/wr_decode_scoreboard.sv
// Writeback address decoder plus per-register busy scoreboard.
// Issue sets a busy bit, writeback clears it and produces a registered
// one-cycle one-hot register-file write enable. Register 0 can be hardwired.
module wr_decode_scoreboard
   import wr_decode_scoreboard_pkg::*;
#(
   parameter int  ADDR_W   = ADDR_W_DEF,
   parameter bit  ZERO_REG = 1'b1,
   localparam int NREG     = 1 << ADDR_W,
   localparam int CNT_W    = busy_cnt_width(ADDR_W)
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              iss_valid,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              iss_ready,
   input  logic              wb_valid,
   input  logic [ADDR_W-1:0] wb_addr,
   output logic [NREG-1:0]   wb_we,
   input  logic [ADDR_W-1:0] rs1_addr,
   input  logic [ADDR_W-1:0] rs2_addr,
   output logic              rs1_busy,
   output logic              rs2_busy,
   output logic [NREG-1:0]   busy,
   output logic [CNT_W-1:0]  busy_cnt,
   output logic              err_wb_idle
);

   logic            iss_fire;
   logic [NREG-1:0] set_raw;
   logic [NREG-1:0] clr_raw;
   logic [NREG-1:0] set_mask;
   logic [NREG-1:0] clr_mask;
   logic [NREG-1:0] busy_next;
   logic            cnt_inc;
   logic            cnt_dec;
   logic            err_hit;

   // No bypass from a same-cycle writeback: readiness looks only at the flops.
   assign iss_ready = !busy[iss_addr];
   assign iss_fire  = iss_valid && iss_ready;
   assign rs1_busy  = busy[rs1_addr];
   assign rs2_busy  = busy[rs2_addr];

   decoder_n #(.ADDR_W(ADDR_W)) u_dec_wb (
      .en     (wb_valid),
      .addr   (wb_addr),
      .onehot (clr_raw)
   );

   decoder_n #(.ADDR_W(ADDR_W)) u_dec_iss (
      .en     (iss_fire),
      .addr   (iss_addr),
      .onehot (set_raw)
   );

   // Masks with register 0 removed when it is hardwired, so r0 never
   // becomes busy and never gets a write enable.
   always_comb begin
      set_mask = set_raw;
      clr_mask = clr_raw;
      if (ZERO_REG) begin
         set_mask[0] = 1'b0;
         clr_mask[0] = 1'b0;
      end
   end

   // Scoreboard next state, counter steps and idle-writeback detection.
   // The set wins over a same-address clear, so a clear only decrements
   // when the bit is busy and not being re-set in the same edge.
   always_comb begin
      busy_next = (busy & ~clr_mask) | set_mask;
      if (ZERO_REG) begin
         busy_next[0] = 1'b0;
      end
      cnt_inc = |(set_mask & ~busy);
      cnt_dec = |(clr_mask & busy & ~set_mask);
      err_hit = wb_valid && !busy[wb_addr] && !(ZERO_REG && (wb_addr == '0));
   end

   // State registers; reset drops any in-flight write-enable pulse.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         busy        <= '0;
         busy_cnt    <= '0;
         wb_we       <= '0;
         err_wb_idle <= 1'b0;
      end else begin
         busy        <= busy_next;
         busy_cnt    <= busy_cnt + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
         wb_we       <= clr_mask;
         err_wb_idle <= err_wb_idle | err_hit;
      end
   end

endmodule

// File: doc/wr_decode_scoreboard.md
# wr_decode_scoreboard

Parametrised successor to the fixed 5-to-32 register-address decoder. It decodes a writeback address into a registered one-hot write-enable vector for the register file. It also keeps a per-register busy scoreboard: busy bits are set at issue and cleared at writeback, so decode can stall on pending destinations. The block sits between the decode/issue stage, the writeback stage and the register-file write enables.

## Interface
- ADDR_W, 5, register address width; NREG = 2**ADDR_W registers
- ZERO_REG, 1, when 1 register 0 is hardwired: never busy, never write-enabled
- clock  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- iss_valid  in  1  issue request with a destination register
- iss_addr  in  ADDR_W  destination register of the issuing instruction
- iss_ready  out  1  issue may be accepted this cycle
- wb_valid  in  1  writeback request
- wb_addr  in  ADDR_W  writeback destination register
- wb_we  out  NREG  registered one-hot register-file write enable
- rs1_addr, rs2_addr  in  ADDR_W  source operands to check
- rs1_busy, rs2_busy  out  1  source register has a pending write
- busy  out  NREG  scoreboard state
- busy_cnt  out  ADDR_W+1  number of set busy bits
- err_wb_idle  out  1  sticky: a writeback targeted a non-busy register (register 0 excluded)

## Operation
- Issue handshake: the issue is accepted when iss_valid && iss_ready.
  - iss_ready = !busy[iss_addr]. It is combinational from registered state, with no bypass from a same-cycle writeback.
  - An accepted issue sets busy[iss_addr] at the next edge.
- Writeback:
  - wb_valid clears busy[wb_addr] at the next edge.
  - It also drives wb_we = onehot(wb_addr) for exactly one cycle, starting on the next edge.
  - wb_valid is never back-pressured.
- Simultaneous accepted issue and writeback to the same address: the set wins and busy stays 1. Cannot occur in legal use, because iss_ready is 0 while that register is busy.
- Simultaneous issue and writeback to different addresses: both updates apply in the same edge.
- ZERO_REG=1:
  - busy[0] is constant 0.
  - Issue to r0 is always ready and leaves no state.
  - Writeback to r0 yields wb_we = 0 and does not set err_wb_idle.
- rsN_busy = busy[rsN_addr], combinational.
- busy_cnt is registered and always equals popcount(busy). It is updated incrementally: +1 on set, −1 on clear, net 0 when both apply to different registers.
- err_wb_idle sets when wb_valid targets a register whose busy bit is 0 (excluding r0 under ZERO_REG). It is cleared only by reset.
- Reset (asynchronous, active-low; may assert mid-operation) forces busy = 0, busy_cnt = 0, wb_we = 0, err_wb_idle = 0. An in-flight wb_we pulse is dropped.
- Reset values: iss_ready = 1 and rs1_busy = rs2_busy = 0, both following from busy = 0.

## Timing
- Writeback to wb_we: 1-cycle latency, pulse width 1 cycle.
- Back-to-back writebacks on consecutive cycles give consecutive one-hot wb_we values, with no bubble.
- Issue to rsN_busy and iss_ready visibility: 1 cycle.
- Writeback to busy clear visibility: 1 cycle. A stalled re-issue to the same register is therefore accepted no earlier than the cycle after wb_valid.
- All outputs except iss_ready and rsN_busy are flop outputs.

## Structure
- Shared package holds:
  - ADDR_W default and derived NREG;
  - the onehot_decode function;
  - the busy count width constant.
- One sub-module: decoder_n, a parametrised ADDR_W-to-2**ADDR_W combinational one-hot decoder with an enable input.
  - Instantiated twice: once for the writeback address (feeding wb_we and the clear mask) and once for the issue address (set mask).
- Scoreboard next-state: busy_next = (busy & ~clr_mask) | set_mask, with bit 0 forced to 0 when ZERO_REG=1.

## Test plan
- Reset: assert reset_n=0 mid-traffic with busy=0x0000_00F0 → busy=0, busy_cnt=0, wb_we=0, err_wb_idle=0 immediately, without waiting for a clock edge.
- Issue then writeback, r5:
  - Issue r5 → busy=0x20 and busy_cnt=1 next cycle, iss_ready=0 for iss_addr=5.
  - Then wb_valid with wb_addr=5 → wb_we=0x20 for one cycle, busy=0, iss_ready=1 the following cycle.
- Sweep all addresses: issue 1..31 back-to-back → busy=0xFFFF_FFFE, busy_cnt=31. Then writeback 31..1 one per cycle → wb_we walks one-hot 0x8000_0000 down to 0x2, busy_cnt reaches 0.
- Simultaneous different addresses: busy[3]=1; issue r7 and writeback r3 in the same cycle → busy=0x80, busy_cnt unchanged at 1.
- Register 0 with ZERO_REG=1:
  - Issue r0 → iss_ready=1, busy unchanged.
  - Writeback r0 → wb_we=0, err_wb_idle=0.
- Idle writeback: writeback r9 with busy[9]=0 → wb_we=0x200 and err_wb_idle=1, remaining 1 until reset. Repeat with ADDR_W=3 → wb_we is 8 bits and busy_cnt is 4 bits.
